nrs_ce_mult_sched: RTL

Scheduler that sequences the signed complex multiplier (`signed_modified_complx_mult`) for NB-IoT LS channel estimation. It accepts a stream of received NRS resource elements with their QPSK pilot bits and issues them to the multiplier's 4-slot result buffer using a write/read ring. It then returns the per-pilot estimates h on a valid/ready interface, counting a fixed number of pilots per subframe. It sits between the RE demapper and the channel-estimate interpolator.

---
 rtl/nrs_ce_mult_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/nrs_ce_mult_sched.sv
// nrs_ce_mult_sched
//   Issues received NRS resource elements and their QPSK pilot bits to the
//   signed complex multiplier's 4-slot result buffer through a write/read ring.
//   The per-pilot LS estimates are returned on a valid/ready interface, and a
//   fixed number of pilots is counted per subframe.
//
// Optional feature macro: CE_TIMEOUT_EN adds a stall watchdog that aborts the
// subframe and pulses sf_err. Without the macro, sf_err is tied to 0.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   start                    one-cycle pulse that opens a subframe (IDLE only)
//   rx_valid/rx_ready        RE input handshake
//   rx_r, rx_i               signed RE, WIDTH_R_I bits
//   nrs_r, nrs_i             pilot QPSK bits (0 = +, 1 = -)
//   mult_en                  multiplier write strobe (set on accept)
//   mult_wr_addr/rd_addr     multiplier slot addresses
//   mult_rx_*, mult_nrs_*    RE and pilot bits passed through to the multiplier
//   mult_real/imag_reg       multiplier buffered result for slot mult_rd_addr
//   h_valid/h_ready          estimate handshake
//   h_r, h_i                 estimate, WIDTH_R_I+1 bits
//   h_idx                    pilot index within the subframe
//   busy                     state is not IDLE
//   sf_done                  one-cycle pulse at subframe completion
//   sf_err                   one-cycle pulse on watchdog abort
module nrs_ce_mult_sched #(
  parameter int unsigned WIDTH_R_I   = 16,
  parameter int unsigned NRS_PER_SF  = 8,
  parameter int unsigned MULT_LAT    = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [WIDTH_R_I-1:0] rx_r,
  input  logic [WIDTH_R_I-1:0] rx_i,
  input  logic                 nrs_r,
  input  logic                 nrs_i,
  output logic                 mult_en,
  output logic [1:0]           mult_wr_addr,
  output logic [1:0]           mult_rd_addr,
  output logic [WIDTH_R_I-1:0] mult_rx_r,
  output logic [WIDTH_R_I-1:0] mult_rx_i,
  output logic                 mult_nrs_r,
  output logic                 mult_nrs_i,
  input  logic [WIDTH_R_I:0]   mult_real_reg,
  input  logic [WIDTH_R_I:0]   mult_imag_reg,
  output logic                 h_valid,
  input  logic                 h_ready,
  output logic [WIDTH_R_I:0]   h_r,
  output logic [WIDTH_R_I:0]   h_i,
  output logic [7:0]           h_idx,
  output logic                 busy,
  output logic                 sf_done,
  output logic                 sf_err
);

  localparam logic [7:0] NRS_N    = 8'(NRS_PER_SF);
  localparam logic [7:0] NRS_LAST = 8'(NRS_PER_SF - 1);
  localparam logic [1:0] LAT      = 2'(MULT_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [7:0] in_cnt;
  logic [7:0] out_cnt;
  logic [1:0] cd [4];   // per-slot countdown until the multiplier result is readable
  logic [3:0] vld;      // per-slot result-ready flags

  logic active;
  logic accept;
  logic pop;
  logic abort;

  // Handshake and pass-through paths; rx_ready never looks at rx_valid.
  assign active       = (state == RUN) || (state == DRAIN);
  assign rx_ready     = (state == RUN) && (count < 3'd4) && (in_cnt < NRS_N);
  assign accept       = rx_valid && rx_ready;
  assign h_valid      = active && vld[rd_ptr];
  assign pop          = h_valid && h_ready;

  assign mult_en      = accept;
  assign mult_wr_addr = wr_ptr;
  assign mult_rd_addr = rd_ptr;
  assign mult_rx_r    = rx_r;
  assign mult_rx_i    = rx_i;
  assign mult_nrs_r   = nrs_r;
  assign mult_nrs_i   = nrs_i;

  assign h_r          = mult_real_reg;
  assign h_i          = mult_imag_reg;
  assign h_idx        = out_cnt;
  assign busy         = (state != IDLE);
  assign sf_done      = (state == DONE);

  // FSM, ring pointers, occupancy and slot tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      vld     <= '0;
      for (int i = 0; i < 4; i++) cd[i] <= '0;
    end else if (abort || ((state == IDLE) && start)) begin
      // Watchdog abort clears like reset; start opens a fresh subframe.
      state   <= abort ? IDLE : RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      vld     <= '0;
      for (int i = 0; i < 4; i++) cd[i] <= '0;
    end else begin
      case (state)
        RUN:     if (accept && (in_cnt == NRS_LAST)) state <= DRAIN;
        DRAIN:   if (pop && (out_cnt == NRS_LAST)) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= state;
      endcase

      if (active) begin
        // Countdowns of slots in flight; a slot turns valid as it hits zero.
        for (int i = 0; i < 4; i++) begin
          if (cd[i] != 2'd0) begin
            cd[i] <= cd[i] - 2'd1;
            if (cd[i] == 2'd1) vld[i] <= 1'b1;
          end
        end

        if (accept) begin
          cd[wr_ptr] <= LAT;
          wr_ptr     <= wr_ptr + 2'd1;
          in_cnt     <= in_cnt + 8'd1;
        end

        // The popped slot is valid with a zero countdown, so it never
        // collides with the accepted slot (count < 4 keeps them apart).
        if (pop) begin
          vld[rd_ptr] <= 1'b0;
          rd_ptr      <= rd_ptr + 2'd1;
          out_cnt     <= out_cnt + 8'd1;
        end

        case ({accept, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef CE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd;

  // Abort once the subframe has made no progress for TIMEOUT_CYC cycles.
  assign abort = active && !accept && !pop && (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd     <= '0;
      sf_err <= 1'b0;
    end else begin
      sf_err <= abort;
      if (!active || accept || pop || abort) wd <= '0;
      else                                   wd <= wd + WD_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign sf_err     = 1'b0;
  assign unused_cfg = ^32'(TIMEOUT_CYC);
`endif

endmodule
